// File: rtl/mole_scheduler_pkg.sv
// Shared definitions for the whack-a-mole round sequencer:
// FSM state codes, LFSR feedback taps, default seed and a feedback helper.
package mole_scheduler_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic lfsr_fb(input logic [15:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR, advancing every clock.
// Ports: clk (clock), rst (sync active-low reset), q (current state, never 0).
import mole_scheduler_pkg::*;

module mole_lfsr16 #(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], lfsr_fb(q)};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: raises one mole at a time, times it out,
// judges presses and keeps score/misses/moles_left.
// Ports: master_clk, rst (sync active-low), tick_lvl (game tick level),
//   start (pulse), btn_hit (press pulses) -> mole_onehot, score, misses,
//   moles_left, busy, game_over.
import mole_scheduler_pkg::*;

module mole_scheduler #(
    parameter int          NUM_HOLES   = 4,
    parameter int          UP_TICKS    = 400,
    parameter int          GAP_TICKS   = 100,
    parameter int          ROUND_MOLES = 20,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic                 master_clk,
    input  logic                 rst,
    input  logic                 tick_lvl,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] btn_hit,
    output logic [NUM_HOLES-1:0] mole_onehot,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic [7:0]           moles_left,
    output logic                 busy,
    output logic                 game_over
);

    localparam int TMAX    = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam int HOLE_W  = $clog2(NUM_HOLES);

    localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_TICKS - 1);
    localparam logic [TIMER_W-1:0] UP_LAST  = TIMER_W'(UP_TICKS - 1);
    localparam logic [HOLE_W-1:0]  HOLE_TOP = HOLE_W'(NUM_HOLES - 1);
    localparam logic [SCORE_W-1:0] CNT_MAX  = '1;

    logic [1:0]         state;
    logic               tick_q;
    logic               tick_p;
    logic [TIMER_W-1:0] timer;
    logic [15:0]        lfsr_q;
    logic [7:0]         hole_mod;
    logic [HOLE_W-1:0]  hole_raw;
    logic [HOLE_W-1:0]  hole_use;
    logic [HOLE_W-1:0]  prev_hole;
    logic               gap_done;
    logic               up_done;
    logic               hit_ok;
    logic               hit_bad;
    logic               last_mole;
    logic               unused_bits;

    mole_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (master_clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign tick_p    = tick_lvl & ~tick_q;
    assign gap_done  = tick_p && (timer == GAP_LAST);
    assign up_done   = tick_p && (timer == UP_LAST);
    assign hit_ok    = |(btn_hit & mole_onehot);
    assign hit_bad   = |(btn_hit & ~mole_onehot);
    assign last_mole = (moles_left <= 8'd1);

    assign hole_mod  = lfsr_q[7:0] % 8'(NUM_HOLES);
    assign hole_raw  = hole_mod[HOLE_W-1:0];

    // Upper LFSR bits and modulo headroom are intentionally not used.
    assign unused_bits = ^{lfsr_q[15:8], hole_mod};

    // Never repeat the previous hole: bump to the next one, wrapping.
    always_comb begin
        hole_use = hole_raw;
        if (hole_raw == prev_hole) begin
            hole_use = (hole_raw == HOLE_TOP) ? '0 : hole_raw + HOLE_W'(1);
        end
    end

    assign busy      = (state == ST_GAP) || (state == ST_UP);
    assign game_over = (state == ST_OVER);

    always_ff @(posedge master_clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            tick_q      <= 1'b0;
            timer       <= '0;
            prev_hole   <= '0;
            mole_onehot <= '0;
            score       <= '0;
            misses      <= '0;
            moles_left  <= '0;
        end else begin
            tick_q <= tick_lvl;
            unique case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state       <= ST_GAP;
                        score       <= '0;
                        misses      <= '0;
                        moles_left  <= 8'(ROUND_MOLES);
                        timer       <= '0;
                        mole_onehot <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state       <= ST_UP;
                        timer       <= '0;
                        prev_hole   <= hole_use;
                        mole_onehot <= NUM_HOLES'(1) << hole_use;
                    end else if (tick_p) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_UP: begin
                    // A correct press beats both timeout and wrong presses.
                    if (hit_ok || up_done) begin
                        if (hit_ok) begin
                            if (score != CNT_MAX) begin
                                score <= score + SCORE_W'(1);
                            end
                        end else if (misses != CNT_MAX) begin
                            misses <= misses + SCORE_W'(1);
                        end
                        if (moles_left != 8'd0) begin
                            moles_left <= moles_left - 8'd1;
                        end
                        mole_onehot <= '0;
                        timer       <= '0;
                        state       <= last_mole ? ST_OVER : ST_GAP;
                    end else begin
                        if (hit_bad && misses != CNT_MAX) begin
                            misses <= misses + SCORE_W'(1);
                        end
                        if (tick_p) begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: expected result snapshots are queued
// by the stimulus and popped by a monitor whenever the DUT's results change.
module tb_mole_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_lvl = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [3:0] mole;
    logic [7:0] score;
    logic [7:0] misses;
    logic [7:0] moles_left;
    logic       busy;
    logic       game_over;

    mole_scheduler #(
        .NUM_HOLES   (4),
        .UP_TICKS    (3),
        .GAP_TICKS   (2),
        .ROUND_MOLES (3),
        .SCORE_W     (8),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .master_clk  (clk),
        .rst         (rst),
        .tick_lvl    (tick_lvl),
        .start       (start),
        .btn_hit     (btn),
        .mole_onehot (mole),
        .score       (score),
        .misses      (misses),
        .moles_left  (moles_left),
        .busy        (busy),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #1 tick_lvl = ~tick_lvl;
        end
    end

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] m;
        logic [7:0] l;
        logic       b;
        logic       g;
    } snap_t;

    snap_t      exp_q[$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    bit         len_chk = 1'b0;
    logic [3:0] last_mole = 4'b0001;

    function automatic snap_t cur();
        return {score, misses, moles_left, busy, game_over};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push(input int s, input int m, input int l,
                        input bit b, input bit g);
        exp_q.push_back({8'(s), 8'(m), 8'(l), b, g});
    endtask

    // Monitor: every change of the result tuple must match the next expectation.
    initial begin
        snap_t prev;
        snap_t now;
        snap_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            now = cur();
            if (mon_en && now !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h want no change", now);
                end else begin
                    e = exp_q.pop_front();
                    if (now !== e) begin
                        errors++;
                        $display("FAIL result_tuple: got %h want %h", now, e);
                    end
                end
            end
            prev = now;
        end
    end

    // Mole watcher: one-hot, never the same hole twice, full-length timeouts.
    initial begin
        logic [3:0] prev_m;
        int         up_len;
        prev_m = '0;
        up_len = 0;
        forever begin
            @(negedge clk);
            if (prev_m == 4'b0 && mole != 4'b0) begin
                chk("mole_onehot", 32'($onehot(mole)), 32'd1);
                chk("hole_differs", 32'(mole != last_mole), 32'd1);
                last_mole = mole;
                up_len = 1;
            end else if (mole != 4'b0) begin
                up_len++;
            end else if (prev_m != 4'b0 && len_chk) begin
                chk("up_len", 32'(up_len), 32'd24);
            end
            prev_m = mole;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        @(posedge clk);
        #1 btn = b;
        @(posedge clk);
        #1 btn = 4'b0;
    endtask

    task automatic wait_mole(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mole == 4'b0 && n < budget);
        chk("wait_mole", 32'(mole != 4'b0), 32'd1);
    endtask

    task automatic wait_go(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!game_over && n < budget);
        chk("wait_game_over", 32'(game_over), 32'd1);
    endtask

    initial begin
        logic [3:0] m;
        logic [3:0] w;

        // 1: reset values, presses in IDLE ignored
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            32'({mole, score, misses, moles_left, busy, game_over}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        press(4'b1111);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_btn_ignored",
            32'({mole, score, misses, moles_left, busy, game_over}), 32'd0);

        // 2: no presses -> three timeouts
        len_chk = 1'b1;
        push(0, 0, 3, 1, 0);
        push(0, 1, 2, 1, 0);
        push(0, 2, 1, 1, 0);
        push(0, 3, 0, 0, 1);
        pulse_start();
        wait_go(400);
        repeat (2) @(negedge clk);
        len_chk = 1'b0;
        chk("timeout_misses", 32'(misses), 32'd3);

        // 3: hit every mole one cycle after it rises
        push(0, 0, 3, 1, 0);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_mole(200);
            m = mole;
            if (i == 2) push(3, 0, 0, 0, 1);
            else push(i + 1, 0, 2 - i, 1, 0);
            press(m);
            @(negedge clk);
            chk("hit_clears_mole", 32'(mole), 32'd0);
        end
        wait_go(10);
        chk("all_hits_score", 32'(score), 32'd3);

        // 4: wrong press adds a miss, mixed press scores
        push(0, 0, 3, 1, 0);
        pulse_start();
        wait_mole(200);
        m = mole;
        w = {m[2:0], m[3]};
        push(0, 1, 3, 1, 0);
        press(w);
        @(negedge clk);
        chk("wrong_mole_stays", 32'(mole), 32'(m));
        push(1, 1, 2, 1, 0);
        press(w | m);
        @(negedge clk);
        chk("mixed_hit_clears", 32'(mole), 32'd0);

        // start while busy is ignored
        pulse_start();
        repeat (3) @(negedge clk);
        chk("start_busy_ignored", 32'(moles_left), 32'd2);

        // 5: correct press lands in the timeout tick cycle
        wait_mole(200);
        m = mole;
        repeat (23) @(posedge clk);
        push(2, 1, 1, 1, 0);
        #1 btn = m;
        @(posedge clk);
        #1 btn = 4'b0;
        @(negedge clk);
        chk("timeout_hit_clears", 32'(mole), 32'd0);

        // 6: reset mid-game, then a fresh game
        wait_mole(200);
        push(0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        last_mole = 4'b0001;
        @(negedge clk);
        chk("reset_mole_cleared", 32'(mole), 32'd0);
        push(0, 0, 3, 1, 0);
        pulse_start();
        wait_mole(200);
        chk("fresh_moles_left", 32'(moles_left), 32'd3);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
